// File: rtl/legv8_pkg.sv
// legv8_pkg
// Shared definitions for the LEGv8 multicycle control unit:
//   - 11-bit opcode constants for the full-width matches, plus the CBZ and B
//     opcode prefixes
//   - 4-bit ALU operation codes (OPADD, OPSUB, OPAND, OPORR)
//   - the control FSM state enum
//   - the instruction-class enum produced by the opcode decoder
package legv8_pkg;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    // CBZ matches on Opcode[10:3]; B matches on Opcode[10:5].
    localparam logic [7:0]  OPC_CBZ_PREFIX = 8'b10110100;
    localparam logic [5:0]  OPC_B_PREFIX   = 6'b000101;

    localparam logic [3:0]  OPADD = 4'b0010;
    localparam logic [3:0]  OPSUB = 4'b0110;
    localparam logic [3:0]  OPAND = 4'b0000;
    localparam logic [3:0]  OPORR = 4'b0001;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_WB_R,
        ST_EXEC_MEM,
        ST_MEM_RD,
        ST_WB_MEM,
        ST_MEM_WR,
        ST_CBZ,
        ST_BR,
        ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        RTYPE,
        LOAD,
        STORE,
        CBZ,
        B,
        ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder
// Purely combinational classification of the 11-bit LEGv8 opcode field.
// Ports:
//   i_opcode   in   11  instruction bits [31:21]
//   o_class    out  instr_class_t  RTYPE / LOAD / STORE / CBZ / B / ILLEGAL
//   o_aluCode  out  4   ALU operation for R-type instructions (ADD otherwise)
module opcode_decoder
    import legv8_pkg::*;
(
    input  logic [10:0]  i_opcode,
    output instr_class_t o_class,
    output logic [3:0]   o_aluCode
);

    // Full-width opcodes are tested before the CBZ/B prefixes so an exact
    // match always wins over a partial one.
    always_comb begin
        o_class   = ILLEGAL;
        o_aluCode = OPADD;
        if (i_opcode == OPC_ADD) begin
            o_class   = RTYPE;
            o_aluCode = OPADD;
        end else if (i_opcode == OPC_SUB) begin
            o_class   = RTYPE;
            o_aluCode = OPSUB;
        end else if (i_opcode == OPC_AND) begin
            o_class   = RTYPE;
            o_aluCode = OPAND;
        end else if (i_opcode == OPC_ORR) begin
            o_class   = RTYPE;
            o_aluCode = OPORR;
        end else if (i_opcode == OPC_LDUR) begin
            o_class   = LOAD;
        end else if (i_opcode == OPC_STUR) begin
            o_class   = STORE;
        end else if (i_opcode[10:3] == OPC_CBZ_PREFIX) begin
            o_class   = CBZ;
        end else if (i_opcode[10:5] == OPC_B_PREFIX) begin
            o_class   = B;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multicycle control FSM for the LEGv8 core: sequences fetch, decode,
// execute, memory and writeback, drives datapath enables, stalls on the
// memory-ready handshake and counts retired instructions.
// Ports:
//   Clock, Reset (sync, active-low)
//   Opcode[10:0], Zero, MemReady                       inputs
//   ALUControlInput[3:0], ALUSrcA, ALUSrcB[1:0], IorD  datapath selects
//   MemRead, MemWrite, IRWrite, RegWrite, MemToReg,
//   Reg2Loc, PCWrite, PCSource                          enables
//   Illegal                                             sticky unknown-opcode flag
//   InstrRetired[31:0]                                  retired-instruction count
module multicycle_control
    import legv8_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic [3:0]  ALUControlInput,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        Reg2Loc,
    output logic        PCWrite,
    output logic        PCSource,
    output logic        Illegal,
    output logic [31:0] InstrRetired
);

    state_t       r_state;
    state_t       w_nextState;
    instr_class_t w_class;
    logic [3:0]   w_rAluCode;
    logic [31:0]  r_instrRetired;
    logic         r_illegal;
    logic         w_retire;

    logic [3:0]   w_aluCtl;
    logic         w_srcA;
    logic [1:0]   w_srcB;
    logic         w_iorD;
    logic         w_memRead;
    logic         w_memWrite;
    logic         w_irWrite;
    logic         w_regWrite;
    logic         w_memToReg;
    logic         w_reg2Loc;
    logic         w_pcWrite;
    logic         w_pcSource;

    opcode_decoder u_opcodeDecoder (
        .i_opcode  (Opcode),
        .o_class   (w_class),
        .o_aluCode (w_rAluCode)
    );

    // State register; reset overrides any transition, including a stalled
    // memory access.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_instrRetired <= '0;
        end else if (w_retire) begin
            r_instrRetired <= r_instrRetired + 32'd1;
        end
    end

    // Sticky illegal flag, set on entry to TRAP and cleared only by reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_illegal <= 1'b0;
        end else if (w_nextState == ST_TRAP) begin
            r_illegal <= 1'b1;
        end
    end

    // Next-state and raw control decode. Memory states hold until MemReady;
    // the CBZ PC write is a Mealy function of Zero.
    always_comb begin
        w_nextState = r_state;
        w_retire    = 1'b0;
        w_aluCtl    = 4'b0000;
        w_srcA      = 1'b0;
        w_srcB      = 2'b00;
        w_iorD      = 1'b0;
        w_memRead   = 1'b0;
        w_memWrite  = 1'b0;
        w_irWrite   = 1'b0;
        w_regWrite  = 1'b0;
        w_memToReg  = 1'b0;
        w_reg2Loc   = 1'b0;
        w_pcWrite   = 1'b0;
        w_pcSource  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_memRead = 1'b1;
                w_srcB    = 2'b01;
                w_aluCtl  = OPADD;
                if (MemReady) begin
                    w_irWrite   = 1'b1;
                    w_pcWrite   = 1'b1;
                    w_nextState = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_srcB   = 2'b11;
                w_aluCtl = OPADD;
                case (w_class)
                    RTYPE:        w_nextState = ST_EXEC_R;
                    LOAD, STORE:  w_nextState = ST_EXEC_MEM;
                    CBZ:          w_nextState = ST_CBZ;
                    B:            w_nextState = ST_BR;
                    default:      w_nextState = ST_TRAP;
                endcase
            end
            ST_EXEC_R: begin
                w_srcA      = 1'b1;
                w_aluCtl    = w_rAluCode;
                w_nextState = ST_WB_R;
            end
            ST_WB_R: begin
                w_regWrite  = 1'b1;
                w_retire    = 1'b1;
                w_nextState = ST_FETCH;
            end
            ST_EXEC_MEM: begin
                w_srcA      = 1'b1;
                w_srcB      = 2'b10;
                w_aluCtl    = OPADD;
                w_nextState = (w_class == LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                w_memRead = 1'b1;
                w_iorD    = 1'b1;
                if (MemReady) begin
                    w_nextState = ST_WB_MEM;
                end
            end
            ST_WB_MEM: begin
                w_regWrite  = 1'b1;
                w_memToReg  = 1'b1;
                w_retire    = 1'b1;
                w_nextState = ST_FETCH;
            end
            ST_MEM_WR: begin
                w_memWrite = 1'b1;
                w_iorD     = 1'b1;
                w_reg2Loc  = 1'b1;
                if (MemReady) begin
                    w_retire    = 1'b1;
                    w_nextState = ST_FETCH;
                end
            end
            ST_CBZ: begin
                w_reg2Loc   = 1'b1;
                w_aluCtl    = OPADD;
                w_pcSource  = 1'b1;
                w_pcWrite   = Zero;
                w_retire    = 1'b1;
                w_nextState = ST_FETCH;
            end
            ST_BR: begin
                w_pcSource  = 1'b1;
                w_pcWrite   = 1'b1;
                w_retire    = 1'b1;
                w_nextState = ST_FETCH;
            end
            ST_TRAP: begin
                w_nextState = ST_TRAP;
            end
            default: begin
                w_nextState = ST_FETCH;
            end
        endcase
    end

    // While Reset is low every output is held at zero, even the FETCH
    // outputs that would otherwise appear combinationally.
    assign ALUControlInput = Reset ? w_aluCtl       : 4'b0000;
    assign ALUSrcA         = Reset ? w_srcA         : 1'b0;
    assign ALUSrcB         = Reset ? w_srcB         : 2'b00;
    assign IorD            = Reset ? w_iorD         : 1'b0;
    assign MemRead         = Reset ? w_memRead      : 1'b0;
    assign MemWrite        = Reset ? w_memWrite     : 1'b0;
    assign IRWrite         = Reset ? w_irWrite      : 1'b0;
    assign RegWrite        = Reset ? w_regWrite     : 1'b0;
    assign MemToReg        = Reset ? w_memToReg     : 1'b0;
    assign Reg2Loc         = Reset ? w_reg2Loc      : 1'b0;
    assign PCWrite         = Reset ? w_pcWrite      : 1'b0;
    assign PCSource        = Reset ? w_pcSource     : 1'b0;
    assign Illegal         = Reset ? r_illegal      : 1'b0;
    assign InstrRetired    = Reset ? r_instrRetired : 32'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed bench for multicycle_control: walks each instruction class
// through its state sequence and compares the full control bundle and the
// retired-instruction counter against hand-derived values every cycle.
module tb_multicycle_control;
    import legv8_pkg::*;

    logic        Clock    = 1'b0;
    logic        Reset    = 1'b0;
    logic [10:0] Opcode   = 11'd0;
    logic        Zero     = 1'b0;
    logic        MemReady = 1'b0;
    logic [3:0]  ALUControlInput;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemToReg;
    logic        Reg2Loc;
    logic        PCWrite;
    logic        PCSource;
    logic        Illegal;
    logic [31:0] InstrRetired;

    int nCompared   = 0;
    int nMismatched = 0;

    localparam logic [10:0] OPC_CBZ_X = 11'b10110100101;
    localparam logic [10:0] OPC_B_X   = 11'b00010110011;
    localparam logic [10:0] OPC_BAD   = 11'h7FF;

    // Control bundle order:
    // {ALU[3:0], SrcA, SrcB[1:0], IorD, MemRead, MemWrite, IRWrite,
    //  RegWrite, MemToReg, Reg2Loc, PCWrite, PCSource, Illegal}
    localparam logic [16:0] C_ZERO       = 17'b0;
    localparam logic [16:0] C_FETCH_WAIT = {4'b0010, 1'b0, 2'b01, 1'b0, 1'b1, 8'b0000_0000};
    localparam logic [16:0] C_FETCH_GO   = {4'b0010, 1'b0, 2'b01, 1'b0, 1'b1, 8'b0100_0100};
    localparam logic [16:0] C_DECODE     = {4'b0010, 1'b0, 2'b11, 10'b0};
    localparam logic [16:0] C_WB_R       = {4'b0000, 1'b0, 2'b00, 10'b00_0010_0000};
    localparam logic [16:0] C_EXEC_MEM   = {4'b0010, 1'b1, 2'b10, 10'b0};
    localparam logic [16:0] C_MEM_RD     = {4'b0000, 1'b0, 2'b00, 10'b11_0000_0000};
    localparam logic [16:0] C_WB_MEM     = {4'b0000, 1'b0, 2'b00, 10'b00_0011_0000};
    localparam logic [16:0] C_MEM_WR     = {4'b0000, 1'b0, 2'b00, 10'b10_1000_1000};
    localparam logic [16:0] C_BR         = {4'b0000, 1'b0, 2'b00, 10'b00_0000_0110};
    localparam logic [16:0] C_TRAP       = {16'b0, 1'b1};

    logic [16:0] ctlBus;
    assign ctlBus = {ALUControlInput, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
                     IRWrite, RegWrite, MemToReg, Reg2Loc, PCWrite, PCSource, Illegal};

    multicycle_control dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Opcode          (Opcode),
        .Zero            (Zero),
        .MemReady        (MemReady),
        .ALUControlInput (ALUControlInput),
        .ALUSrcA         (ALUSrcA),
        .ALUSrcB         (ALUSrcB),
        .IorD            (IorD),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .IRWrite         (IRWrite),
        .RegWrite        (RegWrite),
        .MemToReg        (MemToReg),
        .Reg2Loc         (Reg2Loc),
        .PCWrite         (PCWrite),
        .PCSource        (PCSource),
        .Illegal         (Illegal),
        .InstrRetired    (InstrRetired)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 Clock = ~Clock;

    function automatic logic [16:0] cExecR(input logic [3:0] alu);
        return {alu, 1'b1, 2'b00, 10'b0};
    endfunction

    function automatic logic [16:0] cCbz(input logic z);
        return {4'b0010, 1'b0, 2'b00, 7'b000_0001, z, 1'b1, 1'b0};
    endfunction

    // Drives inputs on the falling edge, then settles before sampling.
    task automatic applyStimulus(input logic [10:0] op, input logic z,
                                 input logic mr, input logic rst);
        @(negedge Clock);
        Opcode   = op;
        Zero     = z;
        MemReady = mr;
        Reset    = rst;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic stepCtl(input string tag, input logic [10:0] op, input logic z,
                           input logic mr, input logic rst, input logic [16:0] exp);
        applyStimulus(op, z, mr, rst);
        checkOutput(tag, {15'b0, ctlBus}, {15'b0, exp});
    endtask

    // Directed sequence; each step advances exactly one clock.
    initial begin
        // Reset held low with MemReady high: everything gated to zero.
        stepCtl("reset gate", OPC_ADD, 1'b0, 1'b1, 1'b0, C_ZERO);
        checkOutput("reset count", InstrRetired, 32'd0);

        // ADD, MemReady tied high: 4 cycles.
        stepCtl("add fetch",  OPC_ADD, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        stepCtl("add decode", OPC_ADD, 1'b0, 1'b1, 1'b1, C_DECODE);
        stepCtl("add exec",   OPC_ADD, 1'b0, 1'b1, 1'b1, cExecR(OPADD));
        stepCtl("add wb",     OPC_ADD, 1'b0, 1'b1, 1'b1, C_WB_R);
        checkOutput("add count before", InstrRetired, 32'd0);

        // SUB with one fetch stall; MemReady low in decode is ignored.
        stepCtl("sub fetch wait", OPC_SUB, 1'b0, 1'b0, 1'b1, C_FETCH_WAIT);
        checkOutput("add count after", InstrRetired, 32'd1);
        stepCtl("sub fetch go", OPC_SUB, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        stepCtl("sub decode",   OPC_SUB, 1'b0, 1'b0, 1'b1, C_DECODE);
        stepCtl("sub exec",     OPC_SUB, 1'b0, 1'b0, 1'b1, cExecR(OPSUB));
        stepCtl("sub wb",       OPC_SUB, 1'b0, 1'b0, 1'b1, C_WB_R);

        // AND and ORR.
        stepCtl("and fetch",  OPC_AND, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        stepCtl("and decode", OPC_AND, 1'b0, 1'b1, 1'b1, C_DECODE);
        stepCtl("and exec",   OPC_AND, 1'b0, 1'b1, 1'b1, cExecR(OPAND));
        stepCtl("and wb",     OPC_AND, 1'b0, 1'b1, 1'b1, C_WB_R);
        stepCtl("orr fetch",  OPC_ORR, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        stepCtl("orr decode", OPC_ORR, 1'b0, 1'b1, 1'b1, C_DECODE);
        stepCtl("orr exec",   OPC_ORR, 1'b0, 1'b1, 1'b1, cExecR(OPORR));
        stepCtl("orr wb",     OPC_ORR, 1'b0, 1'b1, 1'b1, C_WB_R);

        // LDUR with three MemRead stall cycles: 8 cycles total.
        stepCtl("ldur fetch", OPC_LDUR, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        checkOutput("rtype count", InstrRetired, 32'd4);
        stepCtl("ldur decode", OPC_LDUR, 1'b0, 1'b1, 1'b1, C_DECODE);
        stepCtl("ldur exec",   OPC_LDUR, 1'b0, 1'b1, 1'b1, C_EXEC_MEM);
        for (int i = 0; i < 3; i++) begin
            stepCtl("ldur mem stall", OPC_LDUR, 1'b0, 1'b0, 1'b1, C_MEM_RD);
        end
        stepCtl("ldur mem ready", OPC_LDUR, 1'b0, 1'b1, 1'b1, C_MEM_RD);
        stepCtl("ldur wb",        OPC_LDUR, 1'b0, 1'b1, 1'b1, C_WB_MEM);

        // STUR, MemReady high: 4 cycles.
        stepCtl("stur fetch", OPC_STUR, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        checkOutput("ldur count", InstrRetired, 32'd5);
        stepCtl("stur decode", OPC_STUR, 1'b0, 1'b1, 1'b1, C_DECODE);
        stepCtl("stur exec",   OPC_STUR, 1'b0, 1'b1, 1'b1, C_EXEC_MEM);
        stepCtl("stur mem",    OPC_STUR, 1'b0, 1'b1, 1'b1, C_MEM_WR);

        // CBZ taken, then not taken; both retire.
        stepCtl("cbz1 fetch", OPC_CBZ_X, 1'b1, 1'b1, 1'b1, C_FETCH_GO);
        checkOutput("stur count", InstrRetired, 32'd6);
        stepCtl("cbz1 decode", OPC_CBZ_X, 1'b1, 1'b1, 1'b1, C_DECODE);
        stepCtl("cbz1 taken",  OPC_CBZ_X, 1'b1, 1'b1, 1'b1, cCbz(1'b1));
        stepCtl("cbz0 fetch",  OPC_CBZ_X, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        checkOutput("cbz1 count", InstrRetired, 32'd7);
        stepCtl("cbz0 decode", OPC_CBZ_X, 1'b0, 1'b1, 1'b1, C_DECODE);
        stepCtl("cbz0 not taken", OPC_CBZ_X, 1'b0, 1'b1, 1'b1, cCbz(1'b0));

        // Unconditional branch.
        stepCtl("b fetch", OPC_B_X, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        checkOutput("cbz0 count", InstrRetired, 32'd8);
        stepCtl("b decode", OPC_B_X, 1'b0, 1'b1, 1'b1, C_DECODE);
        stepCtl("b br",     OPC_B_X, 1'b0, 1'b1, 1'b1, C_BR);

        // Unknown opcode: trap and stay there for 100 cycles.
        stepCtl("bad fetch", OPC_BAD, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        checkOutput("b count", InstrRetired, 32'd9);
        stepCtl("bad decode", OPC_BAD, 1'b0, 1'b1, 1'b1, C_DECODE);
        for (int i = 0; i < 100; i++) begin
            stepCtl("trap hold", OPC_BAD, 1'b0, i[0], 1'b1, C_TRAP);
        end
        checkOutput("trap count", InstrRetired, 32'd9);

        // Reset leaves the trap; Illegal and the counter clear.
        stepCtl("trap reset", OPC_BAD, 1'b0, 1'b1, 1'b0, C_ZERO);
        stepCtl("after trap", OPC_ADD, 1'b0, 1'b0, 1'b1, C_FETCH_WAIT);
        checkOutput("after trap count", InstrRetired, 32'd0);

        // One ADD so the counter is nonzero, then reset mid-store.
        stepCtl("add2 fetch",  OPC_ADD, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        stepCtl("add2 decode", OPC_ADD, 1'b0, 1'b1, 1'b1, C_DECODE);
        stepCtl("add2 exec",   OPC_ADD, 1'b0, 1'b1, 1'b1, cExecR(OPADD));
        stepCtl("add2 wb",     OPC_ADD, 1'b0, 1'b1, 1'b1, C_WB_R);
        stepCtl("stur2 fetch", OPC_STUR, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        checkOutput("add2 count", InstrRetired, 32'd1);
        stepCtl("stur2 decode", OPC_STUR, 1'b0, 1'b1, 1'b1, C_DECODE);
        stepCtl("stur2 exec",   OPC_STUR, 1'b0, 1'b1, 1'b1, C_EXEC_MEM);
        stepCtl("stur2 stall",  OPC_STUR, 1'b0, 1'b0, 1'b1, C_MEM_WR);
        stepCtl("memwr reset",  OPC_STUR, 1'b0, 1'b0, 1'b0, C_ZERO);
        stepCtl("memwr reset2", OPC_STUR, 1'b0, 1'b1, 1'b0, C_ZERO);
        stepCtl("memwr after",  OPC_B_X,  1'b0, 1'b0, 1'b1, C_FETCH_WAIT);
        checkOutput("memwr count", InstrRetired, 32'd0);

        // Counter wrap: preload all-ones while stalled in FETCH, then a B.
        force dut.r_instrRetired = 32'hFFFF_FFFF;
        stepCtl("wrap wait", OPC_B_X, 1'b0, 1'b0, 1'b1, C_FETCH_WAIT);
        release dut.r_instrRetired;
        checkOutput("wrap preload", InstrRetired, 32'hFFFF_FFFF);
        stepCtl("wrap fetch",  OPC_B_X, 1'b0, 1'b1, 1'b1, C_FETCH_GO);
        stepCtl("wrap decode", OPC_B_X, 1'b0, 1'b1, 1'b1, C_DECODE);
        stepCtl("wrap br",     OPC_B_X, 1'b0, 1'b1, 1'b1, C_BR);
        stepCtl("wrap next",   OPC_ADD, 1'b0, 1'b0, 1'b1, C_FETCH_WAIT);
        checkOutput("wrap count", InstrRetired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the LEGv8 processor core. It decodes the 11-bit opcode field, sequences the shared datapath through fetch, decode, execute, memory and writeback steps, and drives the 4-bit ALU operation code plus all mux, register and memory enables. It stalls on a memory-ready handshake and counts retired instructions. The unit sits between the instruction register and the datapath; the ALU's `Zero` flag is fed back to it for `CBZ`.

## Interface
- No parameters.
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-low; sampled on the rising edge of `Clock`.
- `Opcode`  in  11  bits [31:21] of the instruction register.
- `Zero`  in  1  ALU zero flag; high when ALU operand B == 0.
- `MemReady`  in  1  memory completes the current read or write this cycle.
- `ALUControlInput`  out  4  ALU operation: ADD=0010, SUB=0110, AND=0000, ORR=0001.
- `ALUSrcA`  out  1  operand A select: 0 = OldPC, 1 = register A.
- `ALUSrcB`  out  2  operand B select: 00 = register B, 01 = constant 4, 10 = sign-extended D-offset, 11 = sign-extended branch offset << 2.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`, `MemToReg`, `Reg2Loc`  out  1 each  standard multicycle enables.
- `PCWrite`  out  1  PC load strobe.
- `PCSource`  out  1  PC source select: 0 = ALU result, 1 = ALUOut register.
- `Illegal`  out  1  sticky flag: an unknown opcode was decoded.
- `InstrRetired`  out  32  count of completed instructions.

## Operation
- Opcode matching:
  - R-type opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - Memory opcodes: LDUR 11111000010, STUR 11111000000.
  - CBZ is matched on `Opcode[10:3]` = 10110100.
  - B is matched on `Opcode[10:5]` = 000101.
  - Full-width matches have priority over prefix matches.
- States and what each one drives:
  - FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0 with the PC selected, `ALUSrcB`=01, ADD. Wait here while `MemReady`=0. When `MemReady`=1, pulse `IRWrite` and `PCWrite` (with `PCSource`=0), then go to DECODE.
  - DECODE: `ALUSrcA`=0, `ALUSrcB`=11, ADD; this computes the branch target into ALUOut. Next state is chosen by instruction class: R-type → EXEC_R, LDUR/STUR → EXEC_MEM, CBZ → CBZ, B → BR, anything else → TRAP.
  - EXEC_R: `ALUSrcA`=1, `ALUSrcB`=00, ALU code taken from the opcode, then go to WB_R.
  - WB_R: `RegWrite`=1, `MemToReg`=0, then go to FETCH.
  - EXEC_MEM: `ALUSrcA`=1, `ALUSrcB`=10, ADD, then go to MEM_RD (LDUR) or MEM_WR (STUR).
  - MEM_RD: `MemRead`=1, `IorD`=1. Wait for `MemReady`, then go to WB_MEM.
  - WB_MEM: `RegWrite`=1, `MemToReg`=1, then go to FETCH.
  - MEM_WR: `MemWrite`=1, `IorD`=1, `Reg2Loc`=1. Wait for `MemReady`, then go to FETCH.
  - CBZ: `Reg2Loc`=1, `ALUSrcB`=00, ADD, `PCSource`=1, `PCWrite`=`Zero` (Mealy output), then go to FETCH.
  - BR: `PCSource`=1, `PCWrite`=1, then go to FETCH.
  - TRAP: `Illegal`=1, all enables 0. The unit stays here until `Reset`.
- Outputs not listed for a state are 0.
- `InstrRetired` increments by 1 on the final cycle of each instruction: WB_R, WB_MEM, CBZ, BR, and MEM_WR only when `MemReady`=1. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - A `Reset`=0 sampled at an edge sets state to FETCH, `InstrRetired` to 0 and `Illegal` to 0.
  - While `Reset` is low, every output is forced to 0, including the FETCH combinational outputs.
  - Reset wins over any transition in progress, including a pending memory access.
- Latency with `MemReady` tied high: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3.
- Each cycle of `MemReady`=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- Memory handshake:
  - `MemRead`/`MemWrite` stay asserted, with the address select stable, until the cycle in which `MemReady`=1.
  - `MemReady` outside memory states is ignored.
- `IRWrite` and `PCWrite` in FETCH are single-cycle pulses, coincident with `MemReady`=1.
- `Zero` is sampled only in the CBZ state.

## Structure
- Package `legv8_pkg` holds:
  - the opcode constants;
  - the ALU code constants OPADD, OPSUB, OPAND, OPORR;
  - the state enum;
  - the instruction-class enum (RTYPE, LOAD, STORE, CBZ, B, ILLEGAL).
- Sub-module `opcode_decoder`: combinational, maps `Opcode` to the instruction class and the R-type ALU code. The FSM, output decode and counter stay in `multicycle_control`.

## Test plan
- ADD (10001011000), `MemReady`=1: states FETCH, DECODE, EXEC_R, WB_R. `ALUControlInput`=0010 in EXEC_R, `RegWrite`=1 in cycle 4, `InstrRetired` 0→1.
- LDUR with `MemReady` low for 3 cycles in MEM_RD: `MemRead`/`IorD` held for 4 cycles, `MemToReg`=1 in WB_MEM, total latency 8 cycles.
- CBZ with `Zero`=1 then again with `Zero`=0: `PCWrite`=1 with `PCSource`=1 in the first case, `PCWrite`=0 in the second; both take 3 cycles and both retire.
- Opcode 0x7FF: DECODE→TRAP, `Illegal`=1 held for 100 cycles, `InstrRetired` unchanged. `Reset`=0 then restores FETCH and `Illegal`=0.
- `Reset`=0 asserted in MEM_WR while `MemReady`=0: the next edge gives state FETCH, all outputs 0 during reset, no write pulse, counter 0.
- Counter preloaded (via force) to 0xFFFFFFFF, then B executes: counter reads 0x00000000 after BR.
